// File: rtl/sdm_nc_ctrl.sv
// rtl/sdm_nc_ctrl.sv - SDM noise-cancellation sequencing controller
// Clear, settle, gain ramp, run, and overflow recovery for the accumulator/filter chain.
module sdm_nc_ctrl #(
   parameter int CW      = 12,
   parameter int GW      = 4,
   parameter int CLR_CYC = 4
) (
   input  logic          clk_ref,
   input  logic          rstn,
   input  logic          enable,
   input  logic [CW-1:0] settle_len,
   input  logic [CW-1:0] ramp_step,
   input  logic          ovf,
   output logic          acc_clr,
   output logic          filt_en,
   output logic [GW-1:0] gain,
   output logic          out_valid,
   output logic [2:0]    state,
   output logic [7:0]    ovf_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      SETTLE  = 3'd2,
      RAMP    = 3'd3,
      RUN     = 3'd4,
      RECOVER = 3'd5
   } state_t;

   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
   localparam logic [GW-1:0] GMAX     = '1;
   localparam logic [GW-1:0] G_ONE    = GW'(1);

   state_t        st, nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] s_len, s_nxt;
   logic [CW-1:0] r_len, r_nxt;
   logic [GW-1:0] gain_nxt;
   logic          ovf_hit;
   logic          acc_clr_nxt, filt_en_nxt, out_valid_nxt;
   logic [GW-1:0] gain_out_nxt;

   always_ff @(posedge clk_ref or negedge rstn) begin
      if (!rstn) begin
         st        <= IDLE;
         cnt       <= '0;
         s_len     <= ONE;
         r_len     <= ONE;
         acc_clr   <= 1'b1;
         filt_en   <= 1'b0;
         gain      <= '0;
         out_valid <= 1'b0;
         ovf_cnt   <= '0;
      end else begin
         st        <= nxt;
         cnt       <= cnt_nxt;
         s_len     <= s_nxt;
         r_len     <= r_nxt;
         acc_clr   <= acc_clr_nxt;
         filt_en   <= filt_en_nxt;
         gain      <= gain_out_nxt;
         out_valid <= out_valid_nxt;
         if (ovf_hit && ovf_cnt != 8'hFF)
            ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

   always_comb begin
      nxt      = st;
      cnt_nxt  = cnt + ONE;
      s_nxt    = s_len;
      r_nxt    = r_len;
      gain_nxt = gain;
      ovf_hit  = 1'b0;
      case (st)
         IDLE: begin
            cnt_nxt  = '0;
            gain_nxt = '0;
            if (enable) begin
               nxt   = CLEAR;
               s_nxt = (settle_len == '0) ? ONE : settle_len;
               r_nxt = (ramp_step == '0) ? ONE : ramp_step;
            end
         end
         CLEAR, RECOVER: begin
            gain_nxt = '0;
            if (cnt == CLR_LAST) begin
               nxt     = SETTLE;
               cnt_nxt = '0;
            end
         end
         SETTLE: begin
            gain_nxt = '0;
            if (cnt == s_len - ONE) begin
               nxt     = RAMP;
               cnt_nxt = '0;
            end
         end
         RAMP: begin
            if (cnt == r_len - ONE) begin
               cnt_nxt  = '0;
               gain_nxt = gain + G_ONE;
               if (gain + G_ONE == GMAX)
                  nxt = RUN;
            end
         end
         RUN: begin
            cnt_nxt  = '0;
            gain_nxt = GMAX;
         end
         default: begin
            nxt      = IDLE;
            cnt_nxt  = '0;
            gain_nxt = '0;
         end
      endcase

      // Dropping enable wins over overflow and does not count as an event.
      if (st != IDLE && !enable) begin
         nxt     = IDLE;
         cnt_nxt = '0;
      end else if (ovf && (st == SETTLE || st == RAMP || st == RUN)) begin
         nxt     = RECOVER;
         cnt_nxt = '0;
         ovf_hit = 1'b1;
      end

      acc_clr_nxt   = (nxt == IDLE) || (nxt == CLEAR) || (nxt == RECOVER);
      filt_en_nxt   = (nxt == SETTLE) || (nxt == RAMP) || (nxt == RUN);
      out_valid_nxt = (nxt == RAMP) || (nxt == RUN);
      if (nxt == RUN)
         gain_out_nxt = GMAX;
      else if (nxt == RAMP)
         gain_out_nxt = gain_nxt;
      else
         gain_out_nxt = '0;
   end

   assign state = st;

endmodule

// File: tb/tb_sdm_nc_ctrl.sv
// tb/tb_sdm_nc_ctrl.sv - directed table-driven bench for sdm_nc_ctrl
module tb_sdm_nc_ctrl;

   logic        clk_ref = 1'b0;
   logic        rstn;
   logic        enable;
   logic [11:0] settle_len;
   logic [11:0] ramp_step;
   logic        ovf;
   logic        acc_clr;
   logic        filt_en;
   logic [3:0]  gain;
   logic        out_valid;
   logic [2:0]  state;
   logic [7:0]  ovf_cnt;

   int total = 0;
   int bad   = 0;

   sdm_nc_ctrl #(.CW(12), .GW(4), .CLR_CYC(4)) dut (
      .clk_ref    (clk_ref),
      .rstn       (rstn),
      .enable     (enable),
      .settle_len (settle_len),
      .ramp_step  (ramp_step),
      .ovf        (ovf),
      .acc_clr    (acc_clr),
      .filt_en    (filt_en),
      .gain       (gain),
      .out_valid  (out_valid),
      .state      (state),
      .ovf_cnt    (ovf_cnt)
   );

   always #5 clk_ref = ~clk_ref;

   typedef struct {
      logic        en;
      logic [11:0] sl;
      logic [11:0] rs;
      logic        ov;
      int          n;
      logic [2:0]  e_st;
      logic        e_clr;
      logic        e_fe;
      logic [3:0]  e_gain;
      logic        e_val;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t vt[25];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] e_st, input logic e_clr,
                            input logic e_fe, input logic [3:0] e_gain, input logic e_val,
                            input logic [7:0] e_cnt);
      check({tag, ".state"},     int'(state),     int'(e_st));
      check({tag, ".acc_clr"},   int'(acc_clr),   int'(e_clr));
      check({tag, ".filt_en"},   int'(filt_en),   int'(e_fe));
      check({tag, ".gain"},      int'(gain),      int'(e_gain));
      check({tag, ".out_valid"}, int'(out_valid), int'(e_val));
      check({tag, ".ovf_cnt"},   int'(ovf_cnt),   int'(e_cnt));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_ref);
      #1;
   endtask

   initial begin
      // en, settle, ramp, ovf, edges, state, acc_clr, filt_en, gain, out_valid, ovf_cnt
      vt[0]  = '{1'b1, 12'd10, 12'd2, 1'b0,  1, 3'd1, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0};
      vt[1]  = '{1'b1, 12'd3,  12'd5, 1'b0,  3, 3'd1, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0};
      vt[2]  = '{1'b1, 12'd3,  12'd5, 1'b0,  1, 3'd2, 1'b0, 1'b1, 4'd0,  1'b0, 8'd0};
      vt[3]  = '{1'b1, 12'd3,  12'd5, 1'b0,  9, 3'd2, 1'b0, 1'b1, 4'd0,  1'b0, 8'd0};
      vt[4]  = '{1'b1, 12'd3,  12'd5, 1'b0,  1, 3'd3, 1'b0, 1'b1, 4'd0,  1'b1, 8'd0};
      vt[5]  = '{1'b1, 12'd3,  12'd5, 1'b0,  2, 3'd3, 1'b0, 1'b1, 4'd1,  1'b1, 8'd0};
      vt[6]  = '{1'b1, 12'd3,  12'd5, 1'b0, 26, 3'd3, 1'b0, 1'b1, 4'd14, 1'b1, 8'd0};
      vt[7]  = '{1'b1, 12'd3,  12'd5, 1'b0,  1, 3'd3, 1'b0, 1'b1, 4'd14, 1'b1, 8'd0};
      vt[8]  = '{1'b1, 12'd3,  12'd5, 1'b0,  1, 3'd4, 1'b0, 1'b1, 4'd15, 1'b1, 8'd0};
      vt[9]  = '{1'b1, 12'd3,  12'd5, 1'b0, 10, 3'd4, 1'b0, 1'b1, 4'd15, 1'b1, 8'd0};
      vt[10] = '{1'b1, 12'd3,  12'd5, 1'b1,  1, 3'd5, 1'b1, 1'b0, 4'd0,  1'b0, 8'd1};
      vt[11] = '{1'b1, 12'd3,  12'd5, 1'b0,  3, 3'd5, 1'b1, 1'b0, 4'd0,  1'b0, 8'd1};
      vt[12] = '{1'b1, 12'd3,  12'd5, 1'b0,  1, 3'd2, 1'b0, 1'b1, 4'd0,  1'b0, 8'd1};
      vt[13] = '{1'b1, 12'd3,  12'd5, 1'b0, 10, 3'd3, 1'b0, 1'b1, 4'd0,  1'b1, 8'd1};
      vt[14] = '{1'b1, 12'd3,  12'd5, 1'b0, 30, 3'd4, 1'b0, 1'b1, 4'd15, 1'b1, 8'd1};
      vt[15] = '{1'b1, 12'd3,  12'd5, 1'b1,  1, 3'd5, 1'b1, 1'b0, 4'd0,  1'b0, 8'd2};
      vt[16] = '{1'b1, 12'd3,  12'd5, 1'b1,  4, 3'd2, 1'b0, 1'b1, 4'd0,  1'b0, 8'd2};
      vt[17] = '{1'b1, 12'd3,  12'd5, 1'b1,  1, 3'd5, 1'b1, 1'b0, 4'd0,  1'b0, 8'd3};
      vt[18] = '{1'b1, 12'd3,  12'd5, 1'b0,  4, 3'd2, 1'b0, 1'b1, 4'd0,  1'b0, 8'd3};
      vt[19] = '{1'b1, 12'd3,  12'd5, 1'b0, 12, 3'd3, 1'b0, 1'b1, 4'd1,  1'b1, 8'd3};
      vt[20] = '{1'b0, 12'd3,  12'd5, 1'b1,  1, 3'd0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd3};
      vt[21] = '{1'b1, 12'd0,  12'd0, 1'b0,  1, 3'd1, 1'b1, 1'b0, 4'd0,  1'b0, 8'd3};
      vt[22] = '{1'b1, 12'd7,  12'd7, 1'b0, 19, 3'd3, 1'b0, 1'b1, 4'd14, 1'b1, 8'd3};
      vt[23] = '{1'b1, 12'd7,  12'd7, 1'b0,  1, 3'd4, 1'b0, 1'b1, 4'd15, 1'b1, 8'd3};
      vt[24] = '{1'b0, 12'd7,  12'd7, 1'b0,  1, 3'd0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd3};

      rstn       = 1'b0;
      enable     = 1'b0;
      settle_len = '0;
      ramp_step  = '0;
      ovf        = 1'b0;
      step(3);
      check_all("reset", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
      rstn = 1'b1;
      step(2);
      check_all("idle", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);

      for (int i = 0; i < 25; i++) begin
         enable     = vt[i].en;
         settle_len = vt[i].sl;
         ramp_step  = vt[i].rs;
         ovf        = vt[i].ov;
         step(vt[i].n);
         check_all($sformatf("vec%0d", i), vt[i].e_st, vt[i].e_clr, vt[i].e_fe,
                   vt[i].e_gain, vt[i].e_val, vt[i].e_cnt);
      end

      // Held overflow: one count per RECOVER entry, five edges per loop.
      enable     = 1'b1;
      settle_len = 12'd10;
      ramp_step  = 12'd2;
      ovf        = 1'b1;
      step(6);
      check_all("held_first", 3'd5, 1'b1, 1'b0, 4'd0, 1'b0, 8'd4);
      step(50);
      check_all("held_10", 3'd5, 1'b1, 1'b0, 4'd0, 1'b0, 8'd14);
      step(1500);
      check("sat.ovf_cnt", int'(ovf_cnt), 255);

      ovf    = 1'b0;
      enable = 1'b0;
      step(1);
      check_all("sat_idle", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd255);

      // Async reset in the middle of a ramp.
      enable     = 1'b1;
      settle_len = 12'd0;
      ramp_step  = 12'd3;
      step(9);
      check_all("ramp3", 3'd3, 1'b0, 1'b1, 4'd1, 1'b1, 8'd255);
      #2;
      rstn = 1'b0;
      #1;
      check_all("async_rst", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
      enable = 1'b0;
      step(1);
      rstn = 1'b1;
      step(2);
      check_all("post_rst", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdm_nc_ctrl.md
# sdm_nc_ctrl

Sequencing controller for the SDM noise-cancellation datapath, running in the `clk_ref` domain next to the accumulator/filter chain. On enable it holds the accumulators in clear, lets the filter settle, then ramps the output gain to full scale. On a datapath overflow it mutes the output, re-clears and re-settles. It exposes status (state, overflow count) for debug readback.

## Interface
Parameters:
- `CW`, 12, width of settle/ramp cycle counters and config inputs
- `GW`, 4, gain code width; `GMAX = 2**GW-1` is full scale
- `CLR_CYC`, 4, cycles `acc_clr` is held in CLEAR and RECOVER (≥1)

Ports:
- `clk_ref` in 1: the only clock
- `rstn` in 1: reset, asynchronous, active-low
- `enable` in 1: run request, already synchronous to `clk_ref`
- `settle_len` in CW: settle cycles, latched on IDLE→CLEAR
- `ramp_step` in CW: cycles per gain step, latched on IDLE→CLEAR
- `ovf` in 1: overflow flag from second accumulator, level
- `acc_clr` out 1: synchronous clear to both integrators
- `filt_en` out 1: filter clock enable
- `gain` out GW: output gain code; 0 mutes
- `out_valid` out 1: NC output may be applied downstream
- `state` out 3: current state code
- `ovf_cnt` out 8: saturating overflow-event count

## Operation
- States/codes: IDLE=0, CLEAR=1, SETTLE=2, RAMP=3, RUN=4, RECOVER=5. Codes 6 and 7 are illegal and go to IDLE.
- All outputs come from flops and update on the same edge as the state.
- IDLE: `acc_clr`=1, `filt_en`=0, `gain`=0, `out_valid`=0. Go to CLEAR when `enable`=1. Latch `settle_len` → S and `ramp_step` → R, with 0 treated as 1.
- CLEAR: `acc_clr`=1, `filt_en`=0. Lasts exactly CLR_CYC cycles, then SETTLE.
- SETTLE: `acc_clr`=0, `filt_en`=1, `gain`=0, `out_valid`=0. Lasts S cycles, then RAMP.
- RAMP: `filt_en`=1, `out_valid`=1. `gain` starts at 0 and increments by 1 after every R cycles. On the edge where `gain` becomes GMAX, the state becomes RUN.
- RUN: `gain`=GMAX, `out_valid`=1, `filt_en`=1. Remains until `enable`=0 or `ovf`=1.
- RECOVER (entered on `ovf`=1 in SETTLE, RAMP or RUN):
  - `gain`=0, `out_valid`=0, `acc_clr`=1, `filt_en`=0.
  - Lasts CLR_CYC cycles, then SETTLE using the latched S.
  - `ovf_cnt` increments once per entry and saturates at 255.
- `ovf` is ignored in IDLE, CLEAR and RECOVER. A level held high re-triggers only after SETTLE is re-entered.
- `enable`=0 in any non-IDLE state → IDLE on the next edge. This has priority over `ovf`, and `ovf_cnt` does not increment.
- Config inputs are ignored outside the IDLE→CLEAR edge.
- `ovf_cnt` is cleared only by `rstn`. It persists across enable cycles.

## Timing
- Reset values: state=IDLE, `acc_clr`=1, `filt_en`=0, `gain`=0, `out_valid`=0, `ovf_cnt`=0, S=R=1.
- `enable` sampled high at edge k → CLEAR after edge k.
- SETTLE entered at edge k+CLR_CYC.
- RAMP entered at k+CLR_CYC+S.
- RUN (`gain`=GMAX) at k+CLR_CYC+S+GMAX·R.
- `ovf` sampled high at edge m → RECOVER after edge m, with `gain`=0 and `out_valid`=0 from that edge; SETTLE at m+CLR_CYC.
- `enable` low sampled at edge m → IDLE after m; all outputs at reset values except `ovf_cnt`.
- Simultaneous `enable`=0 and `ovf`=1 → IDLE, `ovf_cnt` unchanged.
- `enable` re-asserted in the cycle IDLE is entered → CLEAR on the following edge. Minimum 1 cycle in IDLE.
- Counters never wrap: settle and step counters reload on every state entry.
- `rstn` asserted mid-sequence → immediate async return to reset values.

## Test plan
- Reset, then `enable`=1 with settle_len=10, ramp_step=2 (CLR_CYC=4, GW=4) → `acc_clr` high 4 cycles, SETTLE 10 cycles, `gain` 1..15 stepping every 2 cycles, RUN 44 cycles after enable edge, `out_valid` rises at cycle 14.
- settle_len=0, ramp_step=0 → treated as 1. RUN reached 4+1+15=20 cycles after enable.
- `ovf` pulse in RUN → `gain`=0, `out_valid`=0 next edge, `acc_clr` 4 cycles, `ovf_cnt`=1, then re-settle and re-ramp to 15. `ovf` held high → one increment per RECOVER entry.
- `enable` and `ovf` both sampled high→low/high on the same edge in RAMP → IDLE, `ovf_cnt` unchanged. Changing `settle_len` mid-run has no effect until the next enable.
- 300 forced overflows → `ovf_cnt` saturates at 255. Async `rstn` pulse mid-RAMP → all outputs at reset values immediately, `ovf_cnt`=0.
